// File: rtl/weight_sched_pkg.sv
// Shared types and helpers for weight_update_scheduler and its row/layer counter.
package weight_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } weight_sched_state_t;

  // Counter width for n positions; a single position still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/weight_update_scheduler_if.sv
// Gradient handshake, shared read port and weight_storage update/read bus.
interface weight_update_scheduler_if #(
  parameter int unsigned data_size = 16,
  parameter int unsigned size      = 3
);
  logic                        grad_valid;
  logic                        grad_ready;
  logic [data_size*size-1:0]   grad_data;
  logic                        rd_req;
  logic [31:0]                 rd_layer;
  logic [31:0]                 rd_row;
  logic                        rd_grant;
  logic [31:0]                 ws_layer_index;
  logic [31:0]                 ws_row_index;
  logic [data_size*size-1:0]   ws_dc_dw;
  logic                        ws_is_update;
  logic [31:0]                 ws_w_layer_index;
  logic [31:0]                 ws_w_row_index;
  logic                        ws_is_read;

  modport master (
    output grad_valid, grad_data, rd_req, rd_layer, rd_row,
    input  grad_ready, rd_grant, ws_layer_index, ws_row_index, ws_dc_dw,
           ws_is_update, ws_w_layer_index, ws_w_row_index, ws_is_read
  );

  modport slave (
    input  grad_valid, grad_data, rd_req, rd_layer, rd_row,
    output grad_ready, rd_grant, ws_layer_index, ws_row_index, ws_dc_dw,
           ws_is_update, ws_w_layer_index, ws_w_row_index, ws_is_read
  );
endinterface

// File: rtl/weight_update_scheduler_layer_row_counter.sv
// Nested row/layer position counter; WEIGHT_SCHED_REVERSE_EN makes layers descend.
module layer_row_counter
  import weight_sched_pkg::*;
#(
  parameter int unsigned size       = 3,
  parameter int unsigned layer_size = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load,
  input  logic                                advance,
  output logic [idx_width(size)-1:0]          row,
  output logic [idx_width(layer_size)-1:0]    layer,
  output logic                                last
);
  localparam int unsigned RW = idx_width(size);
  localparam int unsigned LW = idx_width(layer_size);
  localparam logic [RW-1:0] ROW_LAST = RW'(size - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [LW-1:0] LAY_ONE  = LW'(1);

`ifdef WEIGHT_SCHED_REVERSE_EN
  localparam logic [LW-1:0] LAY_FIRST = LW'(layer_size - 1);
  localparam logic [LW-1:0] LAY_LAST  = '0;
  logic [LW-1:0] layer_next;
  assign layer_next = layer - LAY_ONE;
`else
  localparam logic [LW-1:0] LAY_FIRST = '0;
  localparam logic [LW-1:0] LAY_LAST  = LW'(layer_size - 1);
  logic [LW-1:0] layer_next;
  assign layer_next = layer + LAY_ONE;
`endif

  assign last = (row == ROW_LAST) && (layer == LAY_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row   <= '0;
      layer <= '0;
    end else if (load) begin
      row   <= '0;
      layer <= LAY_FIRST;
    end else if (advance) begin
      if (row == ROW_LAST) begin
        row   <= '0;
        layer <= last ? LAY_FIRST : layer_next;
      end else begin
        row <= row + ROW_ONE;
      end
    end
  end
endmodule

// File: rtl/weight_update_scheduler.sv
// Sweeps every (layer,row), pulls gradient rows and issues updates; reads always win.
// Optional build macro WEIGHT_SCHED_REVERSE_EN sweeps layers from last to first.
module weight_update_scheduler
  import weight_sched_pkg::*;
#(
  parameter int unsigned data_size  = 16,
  parameter int unsigned size       = 3,
  parameter int unsigned layer_size = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  weight_update_scheduler_if.slave bus
);
  localparam int unsigned RW = idx_width(size);
  localparam int unsigned LW = idx_width(layer_size);

  weight_sched_state_t state_q, state_d;
  logic [RW-1:0] row;
  logic [LW-1:0] layer;
  logic last, load, advance, capture, update, ready, conflict;
  logic [data_size*size-1:0] dc_q;

  layer_row_counter #(
    .size       (size),
    .layer_size (layer_size)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .advance (advance),
    .row     (row),
    .layer   (layer),
    .last    (last)
  );

  assign bus.ws_layer_index   = 32'(layer);
  assign bus.ws_row_index     = 32'(row);
  assign bus.ws_dc_dw         = dc_q;
  assign bus.ws_is_update     = update;
  assign bus.grad_ready       = ready;
  assign bus.rd_grant         = bus.rd_req;
  assign bus.ws_is_read       = bus.rd_req;
  assign bus.ws_w_layer_index = bus.rd_layer;
  assign bus.ws_w_row_index   = bus.rd_row;

  assign conflict = bus.rd_req && (bus.rd_layer == bus.ws_layer_index)
                                && (bus.rd_row == bus.ws_row_index);
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    capture = 1'b0;
    update  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        load = 1'b1;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        ready = 1'b1;
        if (bus.grad_valid) begin
          capture = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!conflict) begin
          update  = 1'b1;
          advance = 1'b1;
          state_d = last ? DONE : FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a same-cycle update or capture.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      capture = 1'b0;
      update  = 1'b0;
      advance = 1'b0;
      ready   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) dc_q <= bus.grad_data;
    end
  end
endmodule

// File: tb/tb_weight_update_scheduler.sv
// Directed self-checking bench for weight_update_scheduler with default parameters.
module tb_weight_update_scheduler;
  localparam int unsigned DS = 16;
  localparam int unsigned SZ = 3;
  localparam int unsigned LS = 5;

  logic clk, rst_n, start, abort, busy, done;
  int unsigned tot = 0;
  int unsigned bad = 0;

  weight_update_scheduler_if #(.data_size(DS), .size(SZ)) bus ();

  weight_update_scheduler #(
    .data_size  (DS),
    .size       (SZ),
    .layer_size (LS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_layer(input int unsigned r);
`ifdef WEIGHT_SCHED_REVERSE_EN
    return 32'(LS - 1 - r / SZ);
`else
    return 32'(r / SZ);
`endif
  endfunction

  function automatic logic [31:0] exp_row(input int unsigned r);
    return 32'(r % SZ);
  endfunction

  function automatic logic [DS*SZ-1:0] row_data(input int unsigned r);
    return {16'h1000 + 16'(r), 16'h2000 + 16'(r * 7), 16'hA000 + 16'(r * 3)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bus.grad_valid = 1'b0; bus.grad_data = '0;
    bus.rd_req = 1'b1; bus.rd_layer = 32'd7; bus.rd_row = 32'd9;
    #2;
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    tot++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    tot++; if (bus.grad_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.grad_ready); end
    tot++; if (bus.ws_is_update !== 1'b0) begin bad++; $display("FAIL rst_update: got %b want 0", bus.ws_is_update); end
    tot++; if (bus.ws_dc_dw !== '0) begin bad++; $display("FAIL rst_dc_dw: got %h want 0", bus.ws_dc_dw); end
    tot++; if (bus.ws_layer_index !== 32'd0 || bus.ws_row_index !== 32'd0) begin
      bad++; $display("FAIL rst_index: got %0d,%0d want 0,0", bus.ws_layer_index, bus.ws_row_index); end
    tot++; if (bus.rd_grant !== 1'b1 || bus.ws_is_read !== 1'b1) begin
      bad++; $display("FAIL rst_read: got grant=%b read=%b want 1,1", bus.rd_grant, bus.ws_is_read); end
    tot++; if (bus.ws_w_layer_index !== 32'd7 || bus.ws_w_row_index !== 32'd9) begin
      bad++; $display("FAIL rst_read_addr: got %0d,%0d want 7,9", bus.ws_w_layer_index, bus.ws_w_row_index); end
    bus.rd_req = 1'b0;
    #1;
    tot++; if (bus.rd_grant !== 1'b0) begin bad++; $display("FAIL rst_grant_off: got %b want 0", bus.rd_grant); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_sweep();
    int unsigned r;
    logic exp_upd;
    bus.grad_valid = 1'b1;
    bus.grad_data = row_data(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      r = (c - 1) / 2;
      if (c % 2 == 1 && c < 31) bus.grad_data = row_data(r);
      exp_upd = (c % 2 == 0);
      tot++; if (bus.ws_is_update !== exp_upd) begin
        bad++; $display("FAIL sweep_update c=%0d: got %b want %b", c, bus.ws_is_update, exp_upd); end
      if (exp_upd) begin
        tot++; if (bus.ws_layer_index !== exp_layer(r) || bus.ws_row_index !== exp_row(r)) begin
          bad++; $display("FAIL sweep_addr c=%0d: got %0d,%0d want %0d,%0d", c,
                          bus.ws_layer_index, bus.ws_row_index, exp_layer(r), exp_row(r)); end
        tot++; if (bus.ws_dc_dw !== row_data(r)) begin
          bad++; $display("FAIL sweep_data c=%0d: got %h want %h", c, bus.ws_dc_dw, row_data(r)); end
      end else if (c < 31) begin
        tot++; if (bus.grad_ready !== 1'b1) begin
          bad++; $display("FAIL sweep_ready c=%0d: got %b want 1", c, bus.grad_ready); end
      end
      tot++; if (done !== (c == 31)) begin
        bad++; $display("FAIL sweep_done c=%0d: got %b want %b", c, done, (c == 31)); end
      tot++; if (busy !== 1'b1) begin bad++; $display("FAIL sweep_busy c=%0d: got %b want 1", c, busy); end
      tick();
    end
    tot++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL sweep_idle: got busy=%b done=%b want 0,0", busy, done); end
  endtask

  task automatic test_valid_stall();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned r = 0; r < SZ * LS; r++) begin
      if (r == 4) begin
        bus.grad_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
          tot++; if (bus.grad_ready !== 1'b1 || bus.ws_is_update !== 1'b0) begin
            bad++; $display("FAIL stall_wait w=%0d: got ready=%b upd=%b want 1,0", w, bus.grad_ready, bus.ws_is_update); end
          tick();
        end
        bus.grad_valid = 1'b1;
      end
      bus.grad_data = row_data(r);
      tot++; if (bus.grad_ready !== 1'b1 || bus.ws_is_update !== 1'b0) begin
        bad++; $display("FAIL stall_fetch r=%0d: got ready=%b upd=%b want 1,0", r, bus.grad_ready, bus.ws_is_update); end
      tick();
      tot++; if (bus.ws_is_update !== 1'b1 || bus.ws_layer_index !== exp_layer(r) || bus.ws_row_index !== exp_row(r)) begin
        bad++; $display("FAIL stall_issue r=%0d: got upd=%b at %0d,%0d want 1 at %0d,%0d", r, bus.ws_is_update,
                        bus.ws_layer_index, bus.ws_row_index, exp_layer(r), exp_row(r)); end
      tick();
    end
    tot++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_conflict();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned r = 0; r < SZ * LS; r++) begin
      bus.grad_data = row_data(r);
      tick();
      if (r == 5) begin
        bus.rd_req = 1'b1; bus.rd_layer = exp_layer(r); bus.rd_row = 32'd0;
        #1;
        tot++; if (bus.ws_is_update !== 1'b1) begin
          bad++; $display("FAIL conflict_other_row: got %b want 1", bus.ws_is_update); end
      end
      if (r == 7) begin
        bus.rd_req = 1'b1; bus.rd_layer = exp_layer(r); bus.rd_row = exp_row(r);
        for (int w = 0; w < 2; w++) begin
          #1;
          tot++; if (bus.ws_is_update !== 1'b0 || bus.rd_grant !== 1'b1) begin
            bad++; $display("FAIL conflict_hold w=%0d: got upd=%b grant=%b want 0,1", w, bus.ws_is_update, bus.rd_grant); end
          tot++; if (bus.ws_w_layer_index !== exp_layer(r) || bus.ws_w_row_index !== exp_row(r)) begin
            bad++; $display("FAIL conflict_rd_addr: got %0d,%0d want %0d,%0d", bus.ws_w_layer_index,
                            bus.ws_w_row_index, exp_layer(r), exp_row(r)); end
          tick();
        end
        bus.rd_req = 1'b0;
        #1;
      end
      tot++; if (bus.ws_is_update !== 1'b1 || bus.ws_layer_index !== exp_layer(r) || bus.ws_row_index !== exp_row(r)) begin
        bad++; $display("FAIL conflict_issue r=%0d: got upd=%b at %0d,%0d want 1 at %0d,%0d", r, bus.ws_is_update,
                        bus.ws_layer_index, bus.ws_row_index, exp_layer(r), exp_row(r)); end
      bus.rd_req = 1'b0;
      tick();
    end
    tot++; if (done !== 1'b1) begin bad++; $display("FAIL conflict_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_abort();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned r = 0; r < 9; r++) begin
      tick();
      tot++; if (bus.ws_is_update !== 1'b1) begin bad++; $display("FAIL abort_pre r=%0d: got %b want 1", r, bus.ws_is_update); end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int w = 0; w < 6; w++) begin
      tot++; if (busy !== 1'b0 || done !== 1'b0 || bus.ws_is_update !== 1'b0) begin
        bad++; $display("FAIL abort_idle w=%0d: got busy=%b done=%b upd=%b want 0,0,0", w, busy, done, bus.ws_is_update); end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tot++; if (bus.ws_is_update !== 1'b1 || bus.ws_layer_index !== exp_layer(0) || bus.ws_row_index !== 32'd0) begin
      bad++; $display("FAIL abort_restart: got upd=%b at %0d,%0d want 1 at %0d,0", bus.ws_is_update,
                      bus.ws_layer_index, bus.ws_row_index, exp_layer(0)); end
    tick();
    tick();
    abort = 1'b1;
    #1;
    tot++; if (bus.ws_is_update !== 1'b0) begin bad++; $display("FAIL abort_issue_drop: got %b want 0", bus.ws_is_update); end
    tick();
    abort = 1'b0;
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_issue_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tot++; if (bus.ws_is_update !== 1'b1) begin bad++; $display("FAIL rmid_pre: got %b want 1", bus.ws_is_update); end
    rst_n = 1'b0;
    #1;
    tot++; if (bus.ws_is_update !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.grad_ready !== 1'b0) begin
      bad++; $display("FAIL rmid_ctrl: got upd=%b busy=%b done=%b ready=%b want 0,0,0,0",
                      bus.ws_is_update, busy, done, bus.grad_ready); end
    tot++; if (bus.ws_dc_dw !== '0 || bus.ws_layer_index !== 32'd0 || bus.ws_row_index !== 32'd0) begin
      bad++; $display("FAIL rmid_regs: got dc=%h at %0d,%0d want 0 at 0,0", bus.ws_dc_dw,
                      bus.ws_layer_index, bus.ws_row_index); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 4; w++) begin
      tick();
      tot++; if (busy !== 1'b0 || done !== 1'b0 || bus.ws_is_update !== 1'b0) begin
        bad++; $display("FAIL rmid_after w=%0d: got busy=%b done=%b upd=%b want 0,0,0", w, busy, done, bus.ws_is_update); end
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_valid_stall();
    test_conflict();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
